// File: rtl/jk_pkg.sv
// Shared types and helpers for the JK excitation driver.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

    // Don't-care resolution modes for the unused J or K input.
    localparam int DC_ZERO   = 0;
    localparam int DC_TOGGLE = 1;

    // Returns {j,k} that moves a single JK flip-flop from q to t.
    // The input that does not matter is 0, or 1 on a change when toggle is set.
    function automatic logic [1:0] excite_bit(input logic q, input logic t, input logic toggle);
        logic [1:0] jk;
        jk = 2'b00;
        case ({q, t})
            2'b00:   jk = 2'b00;
            2'b01:   jk = {1'b1, toggle};
            2'b10:   jk = {toggle, 1'b1};
            2'b11:   jk = 2'b00;
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite.sv
// N-bit JK excitation: derives J/K for every bit from the present Q and the target.
module jk_excite
    import jk_pkg::*;
#(
    parameter int N       = 4,
    parameter int DC_MODE = DC_ZERO
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] t,
    output logic [N-1:0] j,
    output logic [N-1:0] k
);

    // Per-bit table lookup; unused inputs resolved according to DC_MODE.
    always_comb begin
        j = {N{1'b0}};
        k = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            {j[i], k[i]} = excite_bit(q[i], t[i], (DC_MODE == DC_TOGGLE));
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop bank to a requested state: one-cycle excitation,
// read-back check, bounded retries, done/err pulses.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_RETRY = 2,
    parameter int DC_MODE   = DC_ZERO,
    localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tgt_valid,
    output logic          tgt_ready,
    input  logic [N-1:0]  tgt,
    input  logic [N-1:0]  q_fb,
    output logic [N-1:0]  j,
    output logic [N-1:0]  k,
    output logic          done,
    output logic          err,
    output logic [N-1:0]  mismatch,
    output logic [RW-1:0] retries
);

    state_e        state_r, state_next;
    logic [N-1:0]  tgt_r, tgt_next;
    logic [N-1:0]  j_r, j_next, k_r, k_next;
    logic [N-1:0]  mm_r, mm_next;
    logic [N-1:0]  t_sel_s, ex_j_s, ex_k_s, diff_s;
    logic [RW-1:0] cnt_r, cnt_next;
    logic          done_r, done_next, err_r, err_next;

    // The excitation block sees the live target while idle (first drive)
    // and the latched target afterwards (retries).
    assign t_sel_s = (state_r == IDLE) ? tgt : tgt_r;
    assign diff_s  = q_fb ^ tgt_r;

    jk_excite #(
        .N       (N),
        .DC_MODE (DC_MODE)
    ) u_excite (
        .q (q_fb),
        .t (t_sel_s),
        .j (ex_j_s),
        .k (ex_k_s)
    );

    // Next-state and next-output logic; j/k default to hold so they are only
    // nonzero in the cycle following an accept or a retry decision.
    always_comb begin
        state_next = state_r;
        tgt_next   = tgt_r;
        cnt_next   = cnt_r;
        mm_next    = mm_r;
        j_next     = {N{1'b0}};
        k_next     = {N{1'b0}};
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_r)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_next   = tgt;
                    cnt_next   = {RW{1'b0}};
                    j_next     = ex_j_s;
                    k_next     = ex_k_s;
                    state_next = DRIVE;
                end else begin
                    state_next = IDLE;
                end
            end
            DRIVE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (diff_s == {N{1'b0}}) begin
                    done_next  = 1'b1;
                    mm_next    = diff_s;
                    state_next = IDLE;
                end else if (cnt_r < RW'(MAX_RETRY)) begin
                    cnt_next   = cnt_r + RW'(1);
                    j_next     = ex_j_s;
                    k_next     = ex_k_s;
                    state_next = DRIVE;
                end else begin
                    err_next   = 1'b1;
                    mm_next    = diff_s;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            tgt_r   <= {N{1'b0}};
            cnt_r   <= {RW{1'b0}};
            mm_r    <= {N{1'b0}};
            j_r     <= {N{1'b0}};
            k_r     <= {N{1'b0}};
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next;
            tgt_r   <= tgt_next;
            cnt_r   <= cnt_next;
            mm_r    <= mm_next;
            j_r     <= j_next;
            k_r     <= k_next;
            done_r  <= done_next;
            err_r   <= err_next;
        end
    end

    // Ready is withheld while reset is asserted so no target slips in.
    assign tgt_ready = (state_r == IDLE) && !rst;
    assign j         = j_r;
    assign k         = k_r;
    assign done      = done_r;
    assign err       = err_r;
    assign mismatch  = mm_r;
    assign retries   = cnt_r;

endmodule
